// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus controller: address map, FSM states and
// region decode. The optional unmapped-access timeout is enabled by MIO_TIMEOUT_EN.
package mio_pkg;

    localparam logic [3:0]  RAM_NIBBLE = 4'h0;
    localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
    localparam logic [31:0] SW_ADDR    = 32'hF000_0004;
    localparam logic [31:0] CYCLE_ADDR = 32'hF000_0008;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } mio_state_e;

    typedef enum logic [2:0] {
        RAM,
        GPIO,
        SW,
        CYCLE,
        UNMAPPED
    } mio_region_e;

    function automatic mio_region_e decode_region(input logic [31:0] a);
        mio_region_e r;
        r = UNMAPPED;
        if (a[31:28] == RAM_NIBBLE) r = RAM;
        else if (a == GPIO_ADDR)    r = GPIO;
        else if (a == SW_ADDR)      r = SW;
        else if (a == CYCLE_ADDR)   r = CYCLE;
        return r;
    endfunction

endpackage

// File: rtl/mio_periph.sv
// Memory-mapped peripheral registers: GPIO (R/W, 16 bit), SW (read-only) and a
// free-running CYCLE counter that a write reloads instead of incrementing.
module mio_periph
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  mio_region_e region_i,
    input  logic [31:0] wdata_i,
    input  logic [15:0] sw_i,
    output logic [15:0] gpio_o,
    output logic [31:0] rd_data_o
);

    logic [15:0] gpio_q;
    logic [31:0] cycle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q  <= '0;
            cycle_q <= '0;
        end else begin
            if (wr_en_i && region_i == GPIO) gpio_q <= wdata_i[15:0];
            if (wr_en_i && region_i == CYCLE) cycle_q <= wdata_i;
            else                              cycle_q <= cycle_q + 32'd1;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (region_i)
            GPIO:    rd_data_o = {16'h0000, gpio_q};
            SW:      rd_data_o = {16'h0000, sw_i};
            CYCLE:   rd_data_o = cycle_q;
            default: rd_data_o = '0;
        endcase
    end

    assign gpio_o = gpio_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU-to-memory/IO bus controller: latches one request, runs it against RAM or
// the peripheral block, and pulses mio_ready. MIO_TIMEOUT_EN adds bus_err.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int RAM_WAIT       = 2,
    parameter int RAM_AW         = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic              cpu_mio,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       gpio_out,
    output mio_state_e        dbg_state
`ifdef MIO_TIMEOUT_EN
    ,
    output logic              bus_err
`endif
);

    localparam int CNT_MAX = (RAM_WAIT > TIMEOUT_CYCLES) ? RAM_WAIT : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    mio_state_e        state_q;
    mio_region_e       region_q;
    mio_region_e       req_region;
    logic              write_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [31:0]       periph_rd;
`ifdef MIO_TIMEOUT_EN
    logic              bus_err_q;
`endif

    assign req_region = decode_region(addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            region_q   <= UNMAPPED;
            write_q    <= 1'b0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
`ifdef MIO_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_mio && (mem_r || mem_w)) begin
                        region_q   <= req_region;
                        write_q    <= mem_w;
                        ram_addr_q <= addr[RAM_AW+1:2];
                        wdata_q    <= wdata;
                        ram_en_q   <= (req_region == RAM);
                        ram_we_q   <= (req_region == RAM) && mem_w;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    if (region_q == RAM) begin
                        if (RAM_WAIT == 0) begin
                            rdata_q <= write_q ? 32'd0 : ram_dout;
                            ready_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_W'(RAM_WAIT);
                            state_q <= WAIT;
                        end
                    end
`ifdef MIO_TIMEOUT_EN
                    else if (region_q == UNMAPPED) begin
                        cnt_q   <= CNT_W'(TIMEOUT_CYCLES);
                        state_q <= WAIT;
                    end
`endif
                    else begin
                        rdata_q <= write_q ? 32'd0 : periph_rd;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                WAIT: begin
                    // The counter reaches zero on the edge that leaves WAIT.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rdata_q   <= (region_q == RAM && !write_q) ? ram_dout : 32'd0;
                        ready_q   <= 1'b1;
                        state_q   <= RESP;
`ifdef MIO_TIMEOUT_EN
                        bus_err_q <= (region_q == UNMAPPED);
`endif
                    end
                end
                RESP: begin
                    ready_q   <= 1'b0;
                    state_q   <= IDLE;
`ifdef MIO_TIMEOUT_EN
                    bus_err_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mio_periph u_periph (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   ((state_q == ACCESS) && write_q),
        .region_i  (region_q),
        .wdata_i   (wdata_q),
        .sw_i      (sw_in),
        .gpio_o    (gpio_out),
        .rd_data_o (periph_rd)
    );

    assign rdata     = rdata_q;
    assign mio_ready = ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = wdata_q;
    assign dbg_state = state_q;
`ifdef MIO_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`endif

endmodule
